// File: rtl/flip_flop_fifo_pow2.sv
// Single-clock show-ahead FIFO in a flip-flop array; pointers carry a wrap bit
// so full/empty fall out of a straight pointer compare.
module flip_flop_fifo_pow2 #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] write_data,
  output logic [width-1:0] read_data,
  output logic             empty,
  output logic             full
);
  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam int pw = aw + 1;

  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("flip_flop_fifo_pow2: depth must be a power of two >= 2");
  end
  if (width < 1) begin : g_bad_width
    $error("flip_flop_fifo_pow2: width must be >= 1");
  end

  logic [width-1:0] mem [depth];
  logic [pw-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);

  // A pop on a full FIFO frees the head slot, so the push may land in it.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + pw'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + pw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr[aw-1:0]] <= write_data;
  end

  assign read_data = mem[rd_ptr[aw-1:0]];
endmodule

// File: tb/tb_flip_flop_fifo_pow2.sv
// Randomised + directed bench for flip_flop_fifo_pow2 against a queue model;
// a negedge monitor checks flags, head word and every popped word.
module tb_flip_flop_fifo_pow2;
  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 0;
  logic         rst = 1;
  logic         push = 0, pop = 0;
  logic [W-1:0] write_data = '0;
  logic [W-1:0] read_data;
  logic         empty, full;

  flip_flop_fifo_pow2 #(.width(W), .depth(D)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .write_data(write_data), .read_data(read_data),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [W-1:0] model [$];
  logic [W-1:0] exp_q [$];
  logic         exp_empty = 1, exp_full = 0;
  logic [W-1:0] exp_head = '0;
  bit           started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: everything it compares against was queued by the driver
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("empty", empty, exp_empty);
      chk("full", full, exp_full);
      if (!exp_empty) chk("head", read_data, exp_head);
      if (pop && !empty) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL pop_unexpected: got %0h expected no pop at %0t", read_data, $time);
        end else chk("pop_data", read_data, exp_q.pop_front());
      end
    end
  end

  // one clock of stimulus; model advances only at the edge
  task automatic cycle(input bit p, input bit q, input logic [W-1:0] d);
    bit acc_push, acc_pop;
    push = p; pop = q; write_data = d;
    exp_empty = (model.size() == 0);
    exp_full  = (model.size() == D);
    exp_head  = (model.size() > 0) ? model[0] : '0;
    acc_pop   = q && model.size() > 0;
    acc_push  = p && (model.size() < D || q);
    if (acc_pop) exp_q.push_back(model[0]);
    @(posedge clk);
    if (acc_pop) void'(model.pop_front());
    if (acc_push) model.push_back(d);
    #1;
  endtask

  task automatic reset_cycle(input bit p, input logic [W-1:0] d);
    rst = 1; push = p; pop = 0; write_data = d;
    @(posedge clk);
    model.delete();
    #1;
    rst = 0; push = 0;
  endtask

  task automatic drain();
    int guard = 0;
    while (model.size() > 0 && guard < 4 * D) begin
      cycle(0, 1, 8'h00);
      guard++;
    end
    if (model.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d left expected 0", model.size());
    end
  endtask

  initial begin
    @(posedge clk); #1;
    reset_cycle(0, 8'h00);
    started = 1;
    cycle(0, 0, 8'h00);                         // reset state

    // fill then empty
    for (int i = 0; i < D; i++) cycle(1, 0, W'(i * 8'h11));
    cycle(0, 0, 8'h00);
    drain();
    cycle(0, 0, 8'h00);

    // streaming at occupancy 4
    for (int i = 0; i < 4; i++) cycle(1, 0, W'(i * 8'h11));
    for (int i = 0; i < 40; i++) cycle(1, 1, W'((i % 8) * 8'h11));
    drain();

    // full with push+pop, then push on full without pop
    for (int i = 0; i < D; i++) cycle(1, 0, W'(8'h50 + i));
    cycle(1, 1, 8'hAA);
    cycle(1, 0, 8'hEE);
    cycle(1, 0, 8'hEF);
    drain();

    // pop on empty, then push+pop on empty (push wins, no bypass)
    cycle(0, 1, 8'h00);
    cycle(1, 1, 8'h3C);
    cycle(0, 0, 8'h00);
    drain();

    // reset mid-operation with a push pending
    for (int i = 0; i < 5; i++) cycle(1, 0, W'(8'h20 + i));
    reset_cycle(1, 8'hDD);
    cycle(0, 0, 8'h00);
    cycle(1, 0, 8'h71);
    cycle(1, 0, 8'h72);
    drain();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      bit p, q;
      if (model.size() == D) begin
        p = ($urandom_range(99) < 40); q = p ? 1'b1 : ($urandom_range(99) < 50);
        if ($urandom_range(99) < 10) begin p = 1; q = 0; end
      end else begin
        p = ($urandom_range(99) < 60);
        q = ($urandom_range(99) < 50);
      end
      cycle(p, q, W'($urandom));
    end
    drain();
    cycle(0, 0, 8'h00);

    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL leftover_pops: got %0d unchecked expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
